// File: rtl/image_pkg.sv
// Shared definitions for the image reader: FSM state encoding, default geometry
// and the test-pattern pixel packing helper.
package image_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int DEF_PIXEL_WIDTH = 24;
    localparam int DEF_ADDR_BITS   = 16;
    localparam int DEF_IMG_W       = 256;
    localparam int DEF_IMG_H       = 256;

    // Synthetic pixel: column, line and frame number packed into one 24-bit word.
    function automatic logic [23:0] pattern_word(input logic [7:0] x,
                                                 input logic [7:0] y,
                                                 input logic [7:0] frame);
        return {x, y, frame};
    endfunction

endpackage

// File: rtl/image_scan_counter.sv
// Raster scan position for the image reader: column/line counters, the linear
// memory address and the end-of-line / end-of-frame flags.
module image_scan_counter #(
    parameter int ADDR_BITS = 16,
    parameter int IMG_W     = 256,
    parameter int IMG_H     = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 advance,
    output logic [ADDR_BITS-1:0] x,
    output logic [ADDR_BITS-1:0] y,
    output logic [ADDR_BITS-1:0] addr,
    output logic                 x_last,
    output logic                 frame_last
);

    localparam logic [ADDR_BITS-1:0] X_MAX = ADDR_BITS'(IMG_W - 1);
    localparam logic [ADDR_BITS-1:0] Y_MAX = ADDR_BITS'(IMG_H - 1);

    assign x_last     = (x == X_MAX);
    assign frame_last = x_last && (y == Y_MAX);

    // The final position is held so the address never runs past the frame.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
        end else if (advance && !frame_last) begin
            addr <= addr + 1'b1;
            if (x_last) begin
                x <= '0;
                y <= y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/image_reader.sv
// Streams one frame from a combinational-read image memory over a valid/ready
// interface. Define IMAGE_READER_TEST_PATTERN_EN to emit a synthetic x/y/frame pattern.
module image_reader
    import image_pkg::*;
#(
    parameter int PIXEL_WIDTH = DEF_PIXEL_WIDTH,
    parameter int ADDR_BITS   = DEF_ADDR_BITS,
    parameter int IMG_W       = DEF_IMG_W,
    parameter int IMG_H       = DEF_IMG_H
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [ADDR_BITS-1:0]   mem_addr,
    input  logic [PIXEL_WIDTH-1:0] mem_data,
    output logic [PIXEL_WIDTH-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_sof,
    output logic                   out_eol,
    output logic                   out_eof
);

    state_t                 state, state_next;
    logic                   load;
    logic                   accept;
    logic                   clear;
    logic [ADDR_BITS-1:0]   x, y;
    logic                   x_last, frame_last, first;
    logic [PIXEL_WIDTH-1:0] pixel;

    image_scan_counter #(
        .ADDR_BITS (ADDR_BITS),
        .IMG_W     (IMG_W),
        .IMG_H     (IMG_H)
    ) u_scan (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .advance    (load),
        .x          (x),
        .y          (y),
        .addr       (mem_addr),
        .x_last     (x_last),
        .frame_last (frame_last)
    );

    assign accept = out_valid && out_ready;
    assign first  = (x == '0) && (y == '0);
    assign busy   = (state != IDLE);

`ifdef IMAGE_READER_TEST_PATTERN_EN
    logic [7:0] frame_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (state == DRAIN && accept) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end

    assign pixel = PIXEL_WIDTH'(pattern_word(8'(x), 8'(y), frame_cnt));
`else
    assign pixel = mem_data;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Counters are parked at zero while idle and cleared as the last pixel leaves.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        clear      = 1'b0;
        case (state)
            IDLE: begin
                clear = 1'b1;
                if (start) begin
                    state_next = READ;
                end
            end
            READ: begin
                load = !out_valid || out_ready;
                if (load && frame_last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (accept) begin
                    clear      = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
        end else begin
            done <= (state == DRAIN) && accept;
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= pixel;
                out_sof   <= first;
                out_eol   <= x_last;
                out_eof   <= frame_last;
            end else if (accept) begin
                out_valid <= 1'b0;
                out_sof   <= 1'b0;
                out_eol   <= 1'b0;
                out_eof   <= 1'b0;
            end
        end
    end

endmodule
